// File: rtl/sram_array_ctrl.sv
// Access controller for a 1R1W SRAM macro: optional power-on clear sweep, round-robin
// read arbitration over two requesters, one write port and a 2-entry response buffer.
// Build option: define SRAM_CTRL_INIT_EN to enable the INIT clear sweep.
module sram_array_ctrl #(
    parameter int                 DEPTH      = 128,
    parameter int                 ADDR_W     = 7,
    parameter int                 DATA_W     = 51,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_r_en,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef SRAM_CTRL_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t              state_reg;
    logic [ADDR_W-1:0]   sweep_cnt_reg;
    logic                init_done_reg;
    logic                rr_ptr_reg;
    logic                s1_valid_reg;
    logic                s1_id_reg;
    logic                s1_byp_reg;
    logic [DATA_W-1:0]   s1_byp_data_reg;
    logic [DATA_W-1:0]   fifo_data_reg [2];
    logic [1:0]          fifo_id_reg;
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [1:0]          occ_reg;

    logic                pop;
    logic                can_accept;
    logic                gnt0;
    logic                gnt1;
    logic                rd_fire;
    logic [ADDR_W-1:0]   rd_addr;
    logic                w_fire;
    logic                init_wr;
    logic                byp;
    logic [DATA_W-1:0]   push_data;

    assign pop        = resp_valid & resp_ready;
    // Admit a read only if the slot it will push into two cycles on is guaranteed free.
    assign can_accept = ({1'b0, occ_reg} + {2'b00, s1_valid_reg}) < (3'd2 + {2'b00, pop});

    assign gnt0 = init_done_reg & can_accept & r0_valid & (~r1_valid | ~rr_ptr_reg);
    assign gnt1 = init_done_reg & can_accept & r1_valid & (~r0_valid |  rr_ptr_reg);

    assign rd_fire = gnt0 | gnt1;
    assign rd_addr = gnt1 ? r1_addr : r0_addr;
    assign w_fire  = w_valid & init_done_reg;
    assign init_wr = (state_reg == ST_INIT) & ~reset;
    // The macro may return old data on a same-cycle collision, so forward the write.
    assign byp     = w_fire & rd_fire & (w_addr == rd_addr);

    assign init_done   = init_done_reg;
    assign w_ready     = init_done_reg;
    assign r0_ready    = gnt0;
    assign r1_ready    = gnt1;
    assign sram_r_en   = rd_fire;
    assign sram_r_addr = rd_addr;
    assign sram_w_en   = init_wr | w_fire;
    assign sram_w_addr = init_wr ? sweep_cnt_reg : w_addr;
    assign sram_w_data = init_wr ? INIT_VALUE : w_data;

    assign push_data   = s1_byp_reg ? s1_byp_data_reg : sram_r_data;
    assign resp_valid  = (occ_reg != 2'd0);
    assign resp_data   = fifo_data_reg[rd_ptr_reg];
    assign resp_id     = fifo_id_reg[rd_ptr_reg];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= RESET_STATE;
            sweep_cnt_reg   <= '0;
            init_done_reg   <= 1'b0;
            rr_ptr_reg      <= 1'b0;
            s1_valid_reg    <= 1'b0;
            s1_id_reg       <= 1'b0;
            s1_byp_reg      <= 1'b0;
            s1_byp_data_reg <= '0;
            fifo_id_reg     <= '0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            occ_reg         <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
                    if (sweep_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: init_done_reg <= 1'b1;
            endcase

            if (rd_fire) begin
                rr_ptr_reg <= gnt0;
            end

            s1_valid_reg <= rd_fire;
            s1_id_reg    <= gnt1;
            s1_byp_reg   <= byp;
            if (byp) begin
                s1_byp_data_reg <= w_data;
            end

            if (s1_valid_reg) begin
                fifo_data_reg[wr_ptr_reg] <= push_data;
                fifo_id_reg[wr_ptr_reg]   <= s1_id_reg;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_reg + {1'b0, s1_valid_reg} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Scoreboard bench for sram_array_ctrl with a read-first 1R1W SRAM model attached.
// Covers the sweep (when SRAM_CTRL_INIT_EN is defined), latency, arbitration, stall, hazards, reset.
module tb_sram_array_ctrl;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 51;
    localparam logic [DATA_W-1:0] PAT   = 51'h5_DEAD_BEEF_1234;
    localparam logic [DATA_W-1:0] ONES  = 51'h7_FFFF_FFFF_FFFF;
    localparam logic [DATA_W-1:0] D200  = 51'h200;
    localparam logic [DATA_W-1:0] D201  = 51'h201;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic init_done, w_valid, w_ready, r0_valid, r0_ready, r1_valid, r1_ready;
    logic resp_valid, resp_ready, resp_id, sram_r_en, sram_w_en;
    logic [ADDR_W-1:0] w_addr, r0_addr, r1_addr, sram_r_addr, sram_w_addr;
    logic [DATA_W-1:0] w_data, resp_data, sram_r_data, sram_w_data;

    logic [DATA_W-1:0] mem [DEPTH];
    logic fill_en = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = 0;
    int last_resp_cyc = 0;
    resp_t sb_q[$];
    logic [DATA_W-1:0] exp0_q[$];
    logic [DATA_W-1:0] exp1_q[$];
    logic grants_q[$];
    int acc_cyc_q[$];
    int resp_cyc_q[$];

    always #5 clock = ~clock;

    sram_array_ctrl dut (
        .clock(clock), .reset(reset), .init_done(init_done),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
    );

    // Read-first macro model: a same-cycle collision returns the old contents.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PAT;
        end else begin
            if (sram_w_en) mem[sram_w_addr] <= sram_w_data;
        end
        if (sram_r_en) sram_r_data <= mem[sram_r_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 ns before each rising edge, records grants and checks responses.
    initial begin
        resp_t e;
        forever begin
            @(negedge clock);
            #4;
            if (!reset) begin
                if (r0_valid && r0_ready) begin
                    acc_cnt++; last_acc_cyc = cyc; grants_q.push_back(1'b0); acc_cyc_q.push_back(cyc);
                    if (exp0_q.size() == 0) chk("r0_unexpected_accept", 1, 0);
                    else begin e.id = 1'b0; e.data = exp0_q.pop_front(); sb_q.push_back(e); end
                end
                if (r1_valid && r1_ready) begin
                    acc_cnt++; last_acc_cyc = cyc; grants_q.push_back(1'b1); acc_cyc_q.push_back(cyc);
                    if (exp1_q.size() == 0) chk("r1_unexpected_accept", 1, 0);
                    else begin e.id = 1'b1; e.data = exp1_q.pop_front(); sb_q.push_back(e); end
                end
                if (r0_ready && r1_ready) chk("double_grant", 1, 0);
                if (resp_valid && resp_ready) begin
                    last_resp_cyc = cyc; resp_cyc_q.push_back(cyc);
                    if (sb_q.size() == 0) chk("resp_unexpected", 1, 0);
                    else begin
                        e = sb_q.pop_front();
                        chk("resp_id", 64'(resp_id), 64'(e.id));
                        chk("resp_data", 64'(resp_data), 64'(e.data));
                        $display("resp id=%0d data=%0h", resp_id, resp_data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        w_valid = 1'b1; w_addr = a; w_data = d;
        tick();
        w_valid = 1'b0;
        $display("write addr=%0d data=%0h", a, d);
    endtask

    task automatic rd(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        int n = 0;
        if (id == 0) begin exp0_q.push_back(exp); r0_valid = 1'b1; r0_addr = a; end
        else begin exp1_q.push_back(exp); r1_valid = 1'b1; r1_addr = a; end
        #4;
        while (!(id == 0 ? r0_ready : r1_ready) && n < 50) begin tick(); #4; n++; end
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        if (n >= 50) chk("rd_timeout", 0, 1);
        $display("read r%0d addr=%0d", id, a);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || exp0_q.size() != 0 || exp1_q.size() != 0) && n < 100) begin
            tick(); n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_init();
`ifdef SRAM_CTRL_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            #4;
            chk("sweep_w_en", 64'(sram_w_en), 1);
            chk("sweep_addr", 64'(sram_w_addr), 64'(i));
            chk("sweep_data", 64'(sram_w_data), 0);
            chk("sweep_init_done", 64'(init_done), 0);
            chk("sweep_r0_ready", 64'(r0_ready | r1_ready | w_ready), 0);
            tick();
        end
        #4;
        chk("init_done_at_depth", 64'(init_done), 1);
        chk("w_en_after_sweep", 64'(sram_w_en), 0);
        tick();
`else
        tick();
        #4;
        chk("init_done_no_sweep", 64'(init_done), 1);
        chk("w_en_no_sweep", 64'(sram_w_en), 0);
        tick();
`endif
    endtask

    initial begin
        logic [7:0] g;
        int a0, n;
        w_valid = 0; w_addr = '0; w_data = '0;
        r0_valid = 0; r0_addr = '0; r1_valid = 0; r1_addr = '0; resp_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        fill_en = 1'b0;
        #4;
        chk("rst_init_done", 64'(init_done), 0);
        chk("rst_readies", 64'({w_ready, r0_ready, r1_ready}), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_id", 64'(resp_id), 0);
        chk("rst_resp_data", 64'(resp_data), 0);
        chk("rst_sram_en", 64'({sram_r_en, sram_w_en}), 0);
        tick();
        reset = 1'b0;
        wait_init();
`ifndef SRAM_CTRL_INIT_EN
        wr(7'd5, '0);
        wr(7'd127, '0);
`endif
        rd(0, 7'd5, '0);
        rd(0, 7'd127, '0);
        drain();

        // Write then read one cycle later, check latency
        wr(7'd3, ONES);
        rd(0, 7'd3, ONES);
        drain();
        chk("read_latency", 64'(last_resp_cyc - last_acc_cyc), 2);

        // Alternating arbitration, full throughput
        wr(7'd20, D200);
        wr(7'd21, D201);
        rd(1, 7'd21, D201);
        drain();
        grants_q.delete(); acc_cyc_q.delete(); resp_cyc_q.delete();
        repeat (4) begin exp0_q.push_back(D200); exp1_q.push_back(D201); end
        r0_addr = 7'd20; r1_addr = 7'd21; r0_valid = 1'b1; r1_valid = 1'b1;
        n = 0;
        while (grants_q.size() < 8 && n < 40) begin tick(); n++; end
        r0_valid = 1'b0; r1_valid = 1'b0;
        drain();
        g = '0;
        for (int i = 0; i < 8 && i < grants_q.size(); i++) g[i] = grants_q[i];
        chk("arb_order", 64'(g), 64'(8'b1010_1010));
        chk("arb_accept_span", 64'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[0]), 7);
        chk("arb_resp_count", 64'(resp_cyc_q.size()), 8);
        chk("arb_resp_span", 64'(resp_cyc_q[resp_cyc_q.size()-1] - resp_cyc_q[0]), 7);

        // Back-pressure: exactly two reads absorbed, then drain and resume
        grants_q.delete();
        repeat (3) begin exp0_q.push_back(D200); exp1_q.push_back(D201); end
        resp_ready = 1'b0; a0 = acc_cnt;
        r0_valid = 1'b1; r1_valid = 1'b1;
        repeat (6) tick();
        #4;
        chk("stall_accepts", 64'(acc_cnt - a0), 2);
        chk("stall_readies", 64'({r0_ready, r1_ready}), 0);
        chk("stall_resp_valid", 64'(resp_valid), 1);
        tick();
        resp_ready = 1'b1;
        n = 0;
        while (acc_cnt - a0 < 6 && n < 30) begin tick(); n++; end
        r0_valid = 1'b0; r1_valid = 1'b0;
        drain();
        g = '0;
        for (int i = 0; i < 6 && i < grants_q.size(); i++) g[i] = grants_q[i];
        chk("stall_order", 64'(g), 64'(8'b0010_1010));

        // Same-cycle write is forwarded; a later write is not
        wr(7'd10, 51'h55);
        exp0_q.push_back(51'hAA);
        w_valid = 1'b1; w_addr = 7'd10; w_data = 51'hAA;
        r0_valid = 1'b1; r0_addr = 7'd10;
        #4;
        chk("hazard_r0_ready", 64'(r0_ready), 1);
        tick();
        r0_valid = 1'b0;
        w_data = 51'h11;
        tick();
        w_valid = 1'b0;
        drain();
        rd(0, 7'd10, 51'h11);
        drain();

        // Reset with two buffered responses
        resp_ready = 1'b0; a0 = acc_cnt;
        exp0_q.push_back(D200); exp1_q.push_back(D201);
        r0_addr = 7'd20; r1_addr = 7'd21; r0_valid = 1'b1; r1_valid = 1'b1;
        n = 0;
        while (acc_cnt - a0 < 2 && n < 20) begin tick(); n++; end
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (2) tick();
        #4;
        chk("pre_reset_resp_valid", 64'(resp_valid), 1);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_reset_resp_valid", 64'(resp_valid), 0);
        chk("mid_reset_init_done", 64'(init_done), 0);
        sb_q.delete(); exp0_q.delete(); exp1_q.delete();
        resp_ready = 1'b1;
        tick();
        reset = 1'b0;
        wait_init();
`ifdef SRAM_CTRL_INIT_EN
        rd(0, 7'd20, '0);
`else
        rd(0, 7'd20, D200);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
